// File: rtl/router_pkg.sv
// router_pkg: shared flit layout, direction codes and output-arbiter FSM encoding
package router_pkg;
    localparam int FLIT_WIDTH = 16;
    localparam int HEAD_BIT = FLIT_WIDTH - 1;
    localparam int TAIL_BIT = FLIT_WIDTH - 2;
    localparam int DEST_LSB = 0;
    localparam int DEST_MSB = 1;
    localparam logic [1:0] DIR_N = 2'b00;
    localparam logic [1:0] DIR_S = 2'b01;
    localparam logic [1:0] DIR_E = 2'b10;
    localparam logic [1:0] DIR_W = 2'b11;
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick starting at ptr
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       any
);
    logic [3:0] rot;
    logic [1:0] off;
    // rotate requests so ptr sits at bit 0, take the first set bit, rotate back
    always_comb begin
        rot = 4'({req, req} >> ptr);
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        idx = ptr + off;
        any = |req;
        gnt = any ? 4'b0001 << idx : 4'b0000;
    end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: per-output-port wormhole round-robin arbiter with registered output stage
module output_port_arbiter #(
    parameter int         NUM_IN     = 4,
    parameter int         FLIT_WIDTH = 16,
    parameter logic [1:0] MY_DIR     = 2'b00
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*FLIT_WIDTH-1:0] in_flit,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [1:0]                   grant_id
);
    import router_pkg::*;

    state_t                  state, state_n;
    logic [1:0]              rr_ptr;
    logic [NUM_IN-1:0]       grant_oh;
    logic [NUM_IN-1:0]       req;
    logic [NUM_IN-1:0]       gnt;
    logic [1:0]              idx;
    logic                    any;
    logic [FLIT_WIDTH-1:0]   gflit;
    logic                    xfer;
    logic                    rel;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_req
        assign req[i] = in_valid[i] & in_flit[i*FLIT_WIDTH + FLIT_WIDTH - 1]
                        & (in_flit[i*FLIT_WIDTH + DEST_LSB +: DEST_MSB - DEST_LSB + 1] == MY_DIR);
    end

    rr_arbiter4 u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    // grant_oh is zero outside LOCKED, so it alone gates the ready of the locked input
    always_comb begin
        gflit    = in_flit[grant_id*FLIT_WIDTH +: FLIT_WIDTH];
        in_ready = grant_oh & {NUM_IN{!out_valid | out_ready}};
        xfer     = |(in_valid & in_ready);
        rel      = xfer & gflit[FLIT_WIDTH-2];
        busy     = (state == LOCKED);
        state_n  = (state == IDLE) ? (any ? LOCKED : IDLE) : (rel ? IDLE : LOCKED);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // lock the winner on arbitration, release and advance the pointer past it on the tail
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_id <= '0;
            grant_oh <= '0;
            rr_ptr   <= '0;
        end else if (state == IDLE && any) begin
            grant_id <= idx;
            grant_oh <= gnt;
        end else if (rel) begin
            grant_id <= '0;
            grant_oh <= '0;
            rr_ptr   <= grant_id + 2'd1;
        end
    end

    // output flit stage: load on transfer, otherwise empty once drained
    always_ff @(posedge clk) begin
        if (reset) begin
            out_flit  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_flit  <= gflit;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed self-checking bench for the output port arbiter (MY_DIR = E)
module tb_output_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_flit = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [15:0] out_flit;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic [1:0]  grant_id;
    int          n_checks = 0;
    int          n_fail = 0;

    localparam logic [1:0] E = 2'b10;

    output_port_arbiter #(.NUM_IN(4), .FLIT_WIDTH(16), .MY_DIR(E)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input bit h, input bit t, input logic [11:0] p, input logic [1:0] d);
        return {h, t, p, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int i, input logic [15:0] f);
        in_flit[i*16 +: 16] = f;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0;
        in_flit = '0;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_flit !== 16'h0) begin n_fail++; $display("FAIL reset out_flit: got %h want 0000", out_flit); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset grant_id: got %0d want 0", grant_id); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset in_ready: got %b want 0000", in_ready); end
        n_checks++; if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset rr_ptr: got %0d want 0", dut.rr_ptr); end
    endtask

    task automatic test_single();
        logic [15:0] f;
        f = mk(1, 1, 12'h123, E);
        set_flit(0, f);
        in_valid = 4'b0001;
        tick();
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL single lock: got busy=%b gid=%0d want busy=1 gid=0", busy, grant_id); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single bubble: got out_valid=%b want 0", out_valid); end
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL single in_ready: got %b want 0001", in_ready); end
        tick();
        in_valid = 4'b0000;
        n_checks++; if (out_valid !== 1'b1 || out_flit !== f) begin n_fail++; $display("FAIL single out: got v=%b f=%h want v=1 f=%h", out_valid, out_flit, f); end
        n_checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL single release: got busy=%b gid=%0d want 0 0", busy, grant_id); end
        n_checks++; if (dut.rr_ptr !== 2'd1) begin n_fail++; $display("FAIL single rr_ptr: got %0d want 1", dut.rr_ptr); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single drain: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [15:0] f [4];
        int exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            f[i] = mk(1, 1, 12'hA00 + 12'(i), E);
            set_flit(i, f[i]);
        end
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            tick();
            n_checks++; if (busy !== 1'b1 || grant_id !== 2'(exp)) begin n_fail++; $display("FAIL rr grant %0d: got busy=%b gid=%0d want 1 %0d", k, busy, grant_id, exp); end
            n_checks++; if (in_ready !== 4'(1 << exp)) begin n_fail++; $display("FAIL rr in_ready %0d: got %b want %b", k, in_ready, 4'(1 << exp)); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_flit !== f[exp]) begin n_fail++; $display("FAIL rr out %0d: got v=%b f=%h want 1 %h", k, out_valid, out_flit, f[exp]); end
        end
        in_valid = 4'b0000;
        n_checks++; if (dut.rr_ptr !== 2'd1) begin n_fail++; $display("FAIL rr final rr_ptr: got %0d want 1", dut.rr_ptr); end
        tick();
    endtask

    task automatic test_wormhole();
        logic [15:0] p [4];
        logic [15:0] h1;
        do_reset();
        p[0] = mk(1, 0, 12'h201, E);
        p[1] = mk(0, 0, 12'h202, E);
        p[2] = mk(0, 0, 12'h203, E);
        p[3] = mk(0, 1, 12'h204, E);
        h1 = mk(1, 1, 12'h111, E);
        set_flit(2, p[0]);
        in_valid = 4'b0100;
        tick();
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL worm grant: got %0d want 2", grant_id); end
        set_flit(1, h1);
        in_valid = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL worm in_ready %0d: got %b want 0100", k, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_flit !== p[k]) begin n_fail++; $display("FAIL worm flit %0d: got v=%b f=%h want 1 %h", k, out_valid, out_flit, p[k]); end
            if (k < 3) set_flit(2, p[k+1]);
        end
        n_checks++; if (busy !== 1'b0 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL worm release: got busy=%b rdy=%b want 0 0000", busy, in_ready); end
        in_valid = 4'b0010;
        tick();
        n_checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL worm next grant: got gid=%0d busy=%b want 1 1", grant_id, busy); end
        tick();
        in_valid = 4'b0000;
        n_checks++; if (out_valid !== 1'b1 || out_flit !== h1) begin n_fail++; $display("FAIL worm input1 flit: got v=%b f=%h want 1 %h", out_valid, out_flit, h1); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] p [4];
        do_reset();
        p[0] = mk(1, 0, 12'h301, E);
        p[1] = mk(0, 0, 12'h302, E);
        p[2] = mk(0, 0, 12'h303, E);
        p[3] = mk(0, 1, 12'h304, E);
        set_flit(3, p[0]);
        in_valid = 4'b1000;
        tick();
        n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL bp grant: got %0d want 3", grant_id); end
        tick();
        n_checks++; if (out_flit !== p[0]) begin n_fail++; $display("FAIL bp head: got %h want %h", out_flit, p[0]); end
        set_flit(3, p[1]);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp stall ready %0d: got %b want 0000", k, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_flit !== p[0]) begin n_fail++; $display("FAIL bp stall out %0d: got v=%b f=%h want 1 %h", k, out_valid, out_flit, p[0]); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp resume ready: got %b want 1000", in_ready); end
        for (int k = 1; k < 4; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_flit !== p[k]) begin n_fail++; $display("FAIL bp flit %0d: got v=%b f=%h want 1 %h", k, out_valid, out_flit, p[k]); end
            if (k < 3) set_flit(3, p[k+1]);
        end
        in_valid = 4'b0000;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp release busy: got %b want 0", busy); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp drain: got %b want 0", out_valid); end
    endtask

    task automatic test_wrong_dest();
        do_reset();
        set_flit(0, mk(1, 1, 12'h400, 2'b00));
        set_flit(1, mk(1, 0, 12'h401, 2'b01));
        set_flit(2, mk(1, 1, 12'h402, 2'b11));
        set_flit(3, mk(0, 1, 12'h403, E));
        in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL dest %0d: got busy=%b v=%b rdy=%b want 0 0 0000", k, busy, out_valid, in_ready); end
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        logic [15:0] f3;
        do_reset();
        set_flit(0, mk(1, 0, 12'h501, E));
        in_valid = 4'b0001;
        tick();
        tick();
        set_flit(0, mk(0, 0, 12'h502, E));
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid pre: got v=%b busy=%b want 1 1", out_valid, busy); end
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL mid reset: got v=%b busy=%b gid=%0d want 0 0 0", out_valid, busy, grant_id); end
        n_checks++; if (dut.rr_ptr !== 2'd0 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL mid reset ptr: got ptr=%0d rdy=%b want 0 0000", dut.rr_ptr, in_ready); end
        f3 = mk(1, 1, 12'h533, E);
        set_flit(3, f3);
        in_valid = 4'b1000;
        tick();
        n_checks++; if (grant_id !== 2'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL mid regrant: got gid=%0d busy=%b want 3 1", grant_id, busy); end
        tick();
        in_valid = 4'b0000;
        n_checks++; if (out_valid !== 1'b1 || out_flit !== f3) begin n_fail++; $display("FAIL mid out: got v=%b f=%h want 1 %h", out_valid, out_flit, f3); end
        n_checks++; if (dut.rr_ptr !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid wrap: got ptr=%0d busy=%b want 0 0", dut.rr_ptr, busy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wormhole();
        test_backpressure();
        test_wrong_dest();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
